// File: rtl/pipelined_memory.sv
// pipelined_memory
//
// Line-organised backing store with one read channel and one write channel.
// Each channel runs its own request/busy/complete handshake with a fixed,
// parameterised latency. Writes are byte-masked. A read and a write that
// complete on the same edge to the same line return the merged (post-write)
// line on the read channel.
//
// Ports
//   clk            single clock, all state on the rising edge
//   rst            asynchronous, active-high reset
//   rReq           read request; accepted on an edge when rBusy is low
//   rAddr          read byte address (line index = rAddr[BYTE_BITS +: IDX_BITS])
//   rBusy          read channel is counting down and ignores rReq
//   rValid         one-cycle pulse: rData holds the requested line
//   rData          read data, held until the next rValid
//   wReq           write request; accepted on an edge when wBusy is low
//   wAddr          write byte address
//   wData          write data
//   wMask          byte enables, bit i covers wData[8i+7:8i]
//   wBusy          write channel is counting down and ignores wReq
//   wDone          one-cycle pulse: the write has been committed
//
// Timing: with the acceptance edge as edge 0, the channel is busy for LAT-1
// cycles and the array access happens on edge LAT-1, so the completion pulse
// is the LAT-th cycle counted from the cycle that presented the request. A
// request held high is re-accepted during the completion cycle, giving one
// transfer per LAT cycles per channel. LAT=1 goes straight to DONE.

module pipelined_memory #(
  parameter int    ARCH_BITS    = 32,
  parameter int    LINE_BITS    = 128,
  parameter int    MEMORY_LINES = 2048,
  parameter int    READ_LAT     = 7,
  parameter int    WRITE_LAT    = 5,
  parameter string INIT_FILE    = "data/memory.dat"
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rReq,
  input  logic [ARCH_BITS-1:0]   rAddr,
  output logic                   rBusy,
  output logic                   rValid,
  output logic [LINE_BITS-1:0]   rData,
  input  logic                   wReq,
  input  logic [ARCH_BITS-1:0]   wAddr,
  input  logic [LINE_BITS-1:0]   wData,
  input  logic [LINE_BITS/8-1:0] wMask,
  output logic                   wBusy,
  output logic                   wDone
);

  localparam int BYTES     = LINE_BITS / 8;
  localparam int BYTE_BITS = $clog2(BYTES);
  localparam int IDX_BITS  = $clog2(MEMORY_LINES);

  // Counter reload values: the number of busy cycles after acceptance.
  localparam logic [3:0] R_LOAD = 4'(READ_LAT - 1);
  localparam logic [3:0] W_LOAD = 4'(WRITE_LAT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t               r_state, r_next;
  state_t               w_state, w_next;
  logic [3:0]           r_cnt, w_cnt;
  logic [IDX_BITS-1:0]  r_idx, w_idx;
  logic [LINE_BITS-1:0] w_data_q;
  logic [BYTES-1:0]     w_mask_q;

  logic [LINE_BITS-1:0] mem [MEMORY_LINES];

  // Address bits outside the line index are ignored, so lines alias.
  logic [IDX_BITS-1:0] r_addr_idx, w_addr_idx;
  assign r_addr_idx = rAddr[BYTE_BITS +: IDX_BITS];
  assign w_addr_idx = wAddr[BYTE_BITS +: IDX_BITS];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{rAddr, wAddr};

  // ---------------------------------------------------------------------
  // Read channel FSM
  // ---------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    r_next = r_state;
    case (r_state)
      WAIT: if (r_cnt == 4'd1) r_next = DONE;
      default: begin
        // IDLE and DONE accept identically.
        r_next = IDLE;
        if (rReq) r_next = (READ_LAT == 1) ? DONE : WAIT;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= r_next;
      if (r_state == WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end else if (rReq) begin
        r_cnt <= R_LOAD;
        r_idx <= r_addr_idx;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Write channel FSM
  // ---------------------------------------------------------------------
  always_comb begin
    w_next = w_state;
    case (w_state)
      WAIT: if (w_cnt == 4'd1) w_next = DONE;
      default: begin
        w_next = IDLE;
        if (wReq) w_next = (WRITE_LAT == 1) ? DONE : WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state  <= IDLE;
      w_cnt    <= '0;
      w_idx    <= '0;
      w_data_q <= '0;
      w_mask_q <= '0;
    end else begin
      w_state <= w_next;
      if (w_state == WAIT) begin
        w_cnt <= w_cnt - 4'd1;
      end else if (wReq) begin
        w_cnt    <= W_LOAD;
        w_idx    <= w_addr_idx;
        w_data_q <= wData;
        w_mask_q <= wMask;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Array access on the edge entering DONE
  // ---------------------------------------------------------------------
  logic r_fire, w_fire;
  assign r_fire = (r_next == DONE);
  assign w_fire = (w_next == DONE);

  // Latched operands while waiting; live inputs when LAT=1 jumps to DONE
  // on the acceptance edge itself.
  logic [IDX_BITS-1:0]  r_acc_idx, w_acc_idx;
  logic [LINE_BITS-1:0] w_acc_data;
  logic [BYTES-1:0]     w_acc_mask;
  assign r_acc_idx  = (r_state == WAIT) ? r_idx    : r_addr_idx;
  assign w_acc_idx  = (w_state == WAIT) ? w_idx    : w_addr_idx;
  assign w_acc_data = (w_state == WAIT) ? w_data_q : wData;
  assign w_acc_mask = (w_state == WAIT) ? w_mask_q : wMask;

  logic [LINE_BITS-1:0] w_merged;
  always_comb begin
    w_merged = mem[w_acc_idx];
    for (int i = 0; i < BYTES; i++) begin
      if (w_acc_mask[i]) w_merged[8*i +: 8] = w_acc_data[8*i +: 8];
    end
  end

  // Same-edge, same-line completion forwards the merged line to the reader.
  logic [LINE_BITS-1:0] r_line;
  assign r_line = (w_fire && (w_acc_idx == r_acc_idx)) ? w_merged : mem[r_acc_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rData <= '0;
    end else if (r_fire) begin
      rData <= r_line;
    end
  end

  // NOTE: the array has no reset; its contents survive rst. The rst term
  // only blocks a LAT=1 write that would otherwise fire while reset is held.
  always_ff @(posedge clk) begin
    if (w_fire && !rst) mem[w_acc_idx] <= w_merged;
  end

  assign rBusy  = (r_state == WAIT);
  assign rValid = (r_state == DONE);
  assign wBusy  = (w_state == WAIT);
  assign wDone  = (w_state == DONE);

endmodule

// File: tb/tb_pipelined_memory.sv
// Scoreboard bench for pipelined_memory. Two instances share the reset:
// dut (READ_LAT=7, WRITE_LAT=5) and dut1 (READ_LAT=1, WRITE_LAT=1).
// Stimulus pushes the expected line and completion cycle into a queue when a
// request is issued; monitors pop and compare on every rValid / wDone.
// Cycle stamps are edge counts sampled on the falling edge.

module tb_pipelined_memory;

  localparam int unsigned RL = 7;
  localparam int unsigned WL = 5;

  localparam logic [127:0] L0 = 128'h000102030405060708090a0b0c0d0e0f;

  typedef struct {
    logic [127:0] data;
    int unsigned  cyc;
  } rexp_t;

  logic clk;
  logic rst;

  logic         rReq, rBusy, rValid, wReq, wBusy, wDone;
  logic [31:0]  rAddr, wAddr;
  logic [127:0] rData, wData;
  logic [15:0]  wMask;

  logic         r1_req, r1_busy, r1_valid, w1_req, w1_busy, w1_done;
  logic [31:0]  r1_addr, w1_addr;
  logic [127:0] r1_data, w1_data;
  logic [15:0]  w1_mask;

  rexp_t       rq[$];
  int unsigned wq[$];
  rexp_t       rq1[$];
  int unsigned wq1[$];

  int unsigned edge_n = 0;
  int          errors = 0;
  int          checks = 0;
  logic        busy1_seen = 1'b0;

  pipelined_memory #(
    .ARCH_BITS(32), .LINE_BITS(128), .MEMORY_LINES(2048),
    .READ_LAT(RL), .WRITE_LAT(WL), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst),
    .rReq(rReq), .rAddr(rAddr), .rBusy(rBusy), .rValid(rValid), .rData(rData),
    .wReq(wReq), .wAddr(wAddr), .wData(wData), .wMask(wMask),
    .wBusy(wBusy), .wDone(wDone)
  );

  pipelined_memory #(
    .ARCH_BITS(32), .LINE_BITS(128), .MEMORY_LINES(2048),
    .READ_LAT(1), .WRITE_LAT(1), .INIT_FILE("")
  ) dut1 (
    .clk(clk), .rst(rst),
    .rReq(r1_req), .rAddr(r1_addr), .rBusy(r1_busy), .rValid(r1_valid), .rData(r1_data),
    .wReq(w1_req), .wAddr(w1_addr), .wData(w1_data), .wMask(w1_mask),
    .wBusy(w1_busy), .wDone(w1_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_r(input logic [127:0] d, input int unsigned c);
    rexp_t e;
    e.data = d;
    e.cyc  = c;
    rq.push_back(e);
  endtask

  task automatic push_r1(input logic [127:0] d, input int unsigned c);
    rexp_t e;
    e.data = d;
    e.cyc  = c;
    rq1.push_back(e);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin : mon_a
    rexp_t e;
    if (rValid) begin
      if (rq.size() == 0) check("rvalid_unexpected", 128'(rValid), 128'd0);
      else begin
        e = rq.pop_front();
        check("rdata", rData, e.data);
        check("rvalid_cycle", 128'(edge_n), 128'(e.cyc));
      end
    end
    if (wDone) begin
      if (wq.size() == 0) check("wdone_unexpected", 128'(wDone), 128'd0);
      else check("wdone_cycle", 128'(edge_n), 128'(wq.pop_front()));
    end
  end

  always @(negedge clk) begin : mon_b
    rexp_t e;
    if (r1_busy || w1_busy) busy1_seen = 1'b1;
    if (r1_valid) begin
      if (rq1.size() == 0) check("lat1_rvalid_unexpected", 128'(r1_valid), 128'd0);
      else begin
        e = rq1.pop_front();
        check("lat1_rdata", r1_data, e.data);
        check("lat1_rvalid_cycle", 128'(edge_n), 128'(e.cyc));
      end
    end
    if (w1_done) begin
      if (wq1.size() == 0) check("lat1_wdone_unexpected", 128'(w1_done), 128'd0);
      else check("lat1_wdone_cycle", 128'(edge_n), 128'(wq1.pop_front()));
    end
  end

  // ---------------- stimulus helpers (called on a falling edge) ----------------
  task automatic wr(input logic [31:0] a, input logic [127:0] d, input logic [15:0] m);
    wReq = 1'b1; wAddr = a; wData = d; wMask = m;
    wq.push_back(edge_n + WL);
    @(negedge clk);
    // Post-acceptance input changes must have no effect.
    wReq = 1'b0; wAddr = 32'hFFFF_FFF0; wData = '0; wMask = '1;
    repeat (WL - 1) @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] a, input logic [127:0] exp);
    rReq = 1'b1; rAddr = a;
    push_r(exp, edge_n + RL);
    @(negedge clk);
    rReq = 1'b0; rAddr = 32'hFFFF_FFFF;
    repeat (RL - 1) @(negedge clk);
  endtask

  // Read issued first, write issued 'gap' cycles later.
  task automatic overlap(input logic [31:0] ra, input logic [127:0] rexp, input int gap,
                         input logic [31:0] wa, input logic [127:0] wd, input logic [15:0] wm);
    rReq = 1'b1; rAddr = ra;
    push_r(rexp, edge_n + RL);
    @(negedge clk);
    rReq = 1'b0; rAddr = 32'hFFFF_FFFF;
    repeat (gap - 1) @(negedge clk);
    wReq = 1'b1; wAddr = wa; wData = wd; wMask = wm;
    wq.push_back(edge_n + WL);
    @(negedge clk);
    wReq = 1'b0; wAddr = 32'hFFFF_FFF0; wData = '0; wMask = '1;
    repeat (10) @(negedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    rReq = 1'b0; rAddr = '0; wReq = 1'b0; wAddr = '0; wData = '0; wMask = '0;
    r1_req = 1'b0; r1_addr = '0; w1_req = 1'b0; w1_addr = '0; w1_data = '0; w1_mask = '0;

    repeat (3) @(negedge clk);
    check("rst_rbusy",  128'(rBusy),  128'd0);
    check("rst_rvalid", 128'(rValid), 128'd0);
    check("rst_rdata",  rData,        128'd0);
    check("rst_wbusy",  128'(wBusy),  128'd0);
    check("rst_wdone",  128'(wDone),  128'd0);
    rst = 1'b0;

    // Load lines 0..6 through the write port with full masks.
    wr(32'h00, L0, 16'hFFFF);
    wr(32'h10, {16{8'h11}}, 16'hFFFF);
    wr(32'h20, {16{8'h22}}, 16'hFFFF);
    wr(32'h30, 128'h3, 16'hFFFF);
    wr(32'h40, {16{8'h44}}, 16'hFFFF);
    wr(32'h50, {16{8'h55}}, 16'hFFFF);
    wr(32'h60, {16{8'h66}}, 16'hFFFF);

    // Read timing: busy cycles 1..6, pulse cycle 7, data held cycle 8.
    rReq = 1'b1; rAddr = 32'h30;
    push_r(128'h3, edge_n + RL);
    @(negedge clk);
    rReq = 1'b0; rAddr = 32'h40;
    check("rbusy_cycle1", 128'(rBusy), 128'd1);
    for (int c = 2; c < int'(RL); c++) begin
      @(negedge clk);
      check("rbusy_mid", 128'(rBusy), 128'd1);
    end
    @(negedge clk);
    check("rbusy_cycle7", 128'(rBusy), 128'd0);
    @(negedge clk);
    check("rvalid_cycle8", 128'(rValid), 128'd0);
    check("rdata_held", rData, 128'h3);

    // Byte-masked write: low 4 bytes replaced.
    wr(32'h40, {16{8'hAA}}, 16'h000F);
    rd(32'h40, 128'h44444444_44444444_44444444_AAAAAAAA);

    // Same-edge collision on line 5: read sees the merged line.
    overlap(32'h50, 128'h55555555_55555555_BBBBBBBB_55555555, 2,
            32'h5C, {16{8'hBB}}, 16'h00F0);
    rd(32'h58, 128'h55555555_55555555_BBBBBBBB_55555555);

    // Write completes one edge before the read: new data visible.
    overlap(32'h20, {16{8'hC1}}, 1, 32'h20, {16{8'hC1}}, 16'hFFFF);
    // Write completes one edge after the read: old data returned.
    overlap(32'h10, {16{8'h11}}, 3, 32'h14, {16{8'hC3}}, 16'hFFFF);
    rd(32'h10, {16{8'hC3}});

    // rReq held high: accepted every RL cycles, busy-time changes ignored.
    rReq = 1'b1; rAddr = 32'h00;
    push_r(L0, edge_n + RL);
    for (int c = 1; c <= 2 * int'(RL); c++) begin
      @(negedge clk);
      if (c == int'(RL)) begin
        check("held_rbusy_done", 128'(rBusy), 128'd0);
        rAddr = 32'h10;
        push_r({16{8'hC3}}, edge_n + RL);
      end else if (c == 2 * int'(RL)) begin
        rAddr = 32'h20;
        push_r({16{8'hC1}}, edge_n + RL);
      end else begin
        rAddr = 32'h60;
      end
    end
    @(negedge clk);
    rReq = 1'b0;
    repeat (RL) @(negedge clk);

    // Zero mask completes without changing the line.
    wr(32'h00, {16{8'hFF}}, 16'h0000);
    rd(32'h00, L0);

    // High address bits alias onto line 3.
    rd(32'h8000_8030, 128'h3);

    // Reset at cycle 3 of a pending write (and read): everything drops.
    wReq = 1'b1; wAddr = 32'h60; wData = {16{8'hEE}}; wMask = 16'hFFFF;
    rReq = 1'b1; rAddr = 32'h10;
    @(negedge clk);
    wReq = 1'b0; rReq = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_wbusy", 128'(wBusy), 128'd1);
    check("pre_rst_rbusy", 128'(rBusy), 128'd1);
    check("pre_rst_rdata", rData, 128'h3);
    #2 rst = 1'b1;
    #1;
    check("async_rst_rbusy",  128'(rBusy),  128'd0);
    check("async_rst_rvalid", 128'(rValid), 128'd0);
    check("async_rst_rdata",  rData,        128'd0);
    check("async_rst_wbusy",  128'(wBusy),  128'd0);
    check("async_rst_wdone",  128'(wDone),  128'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    rd(32'h60, {16{8'h66}});

    // LAT=1 instance: back-to-back writes then reads, one per cycle.
    for (int i = 0; i < 4; i++) begin
      w1_req = 1'b1; w1_addr = 32'(i * 16);
      w1_data = {16{8'(8'h11 * (i + 1))}}; w1_mask = 16'hFFFF;
      wq1.push_back(edge_n + 1);
      @(negedge clk);
    end
    w1_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r1_req = 1'b1; r1_addr = 32'(i * 16 + 4);
      push_r1({16{8'(8'h11 * (i + 1))}}, edge_n + 1);
      @(negedge clk);
    end
    // Read and write of line 3 accepted and completed on the same edge.
    r1_addr = 32'h30;
    push_r1(128'h44444444_44444444_CDCDCDCD_CDCDCDCD, edge_n + 1);
    w1_req = 1'b1; w1_addr = 32'h38; w1_data = {16{8'hCD}}; w1_mask = 16'h00FF;
    wq1.push_back(edge_n + 1);
    @(negedge clk);
    w1_req = 1'b0;
    r1_addr = 32'h30;
    push_r1(128'h44444444_44444444_CDCDCDCD_CDCDCDCD, edge_n + 1);
    @(negedge clk);
    r1_req = 1'b0;
    repeat (3) @(negedge clk);

    check("lat1_never_busy", 128'(busy1_seen), 128'd0);
    check("rq_drained",  128'(rq.size()),  128'd0);
    check("wq_drained",  128'(wq.size()),  128'd0);
    check("rq1_drained", 128'(rq1.size()), 128'd0);
    check("wq1_drained", 128'(wq1.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
